// File: rtl/jtframe_mr_dwnld.sv
// Splits wide download words into byte writes spaced GAP+1 cycles apart, and
// captures DIP-switch and core-mode bytes from the resulting byte stream.
module jtframe_mr_dwnld #(
    parameter int         DIN_W     = 16,
    parameter int         GAP       = 24,
    parameter int         DIPBYTES  = 4,
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter logic [7:0] DIP_INDEX = 8'd254,
    parameter logic [7:0] MOD_INDEX = 8'd1
) (
    input  logic                  clk_rom,
    input  logic                  rst,
    input  logic                  dwnld_wr,
    input  logic [26:0]           dwnld_addr,
    input  logic [DIN_W-1:0]      dwnld_data,
    input  logic [7:0]            dwnld_index,
    input  logic                  dwnld_active,
    output logic                  ioctl_wr,
    output logic [24:0]           ioctl_addr,
    output logic [7:0]            ioctl_data,
    output logic                  ioctl_rom_wr,
    output logic [8*DIPBYTES-1:0] dipsw,
    output logic [6:0]            core_mod,
    output logic                  busy,
    output logic                  overrun
);
    localparam int              NB        = DIN_W / 8;
    localparam int              LB        = $clog2(NB);
    localparam int              KW        = (LB == 0) ? 1 : LB;
    localparam logic [24:0]     ADDR_MASK = ~25'(NB - 1);
    localparam logic [7:0]      GAP_LAST  = 8'(GAP - 1);
    localparam logic [KW-1:0]   K_LAST    = KW'(NB - 1);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

    state_t               state, state_next;
    logic [KW-1:0]        k, k_next, k_inc;
    logic [7:0]           cnt, cnt_next;
    logic [NB-1:0][7:0]   word_q;
    logic [24:0]          addr_q;
    logic [7:0]           idx_q;
    logic                 wr_next;
    logic [24:0]          addr_next;
    logic [7:0]           data_next;
    logic                 accept, drop, active_q;
    logic                 unused_bits;

    assign k_inc        = k + KW'(1);
    assign busy         = (state != IDLE);
    assign accept       = (state == IDLE) && dwnld_wr;
    assign drop         = (state != IDLE) && dwnld_wr;
    assign ioctl_rom_wr = ioctl_wr && (idx_q == ROM_INDEX);
    assign unused_bits  = ^dwnld_addr[26:25];

    // NOTE: every combinational output gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        k_next     = k;
        cnt_next   = cnt;
        wr_next    = 1'b0;
        addr_next  = ioctl_addr;
        data_next  = ioctl_data;
        case (state)
            IDLE: if (dwnld_wr) begin
                state_next = EMIT;
                k_next     = '0;
                wr_next    = 1'b1;
                addr_next  = dwnld_addr[24:0] & ADDR_MASK;
                data_next  = dwnld_data[7:0];
            end
            EMIT: if (k != K_LAST) begin
                state_next = WAIT;
                cnt_next   = '0;
            end else begin
                state_next = IDLE;
            end
            WAIT: if (cnt == GAP_LAST) begin
                state_next = EMIT;
                k_next     = k_inc;
                wr_next    = 1'b1;
                addr_next  = addr_q | 25'(k_inc);
                data_next  = word_q[k_inc];
            end else begin
                cnt_next = cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            cnt        <= '0;
            ioctl_wr   <= 1'b0;
            ioctl_addr <= '0;
            ioctl_data <= '0;
            active_q   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            k          <= k_next;
            cnt        <= cnt_next;
            ioctl_wr   <= wr_next;
            ioctl_addr <= addr_next;
            ioctl_data <= data_next;
            active_q   <= dwnld_active;
            if (drop)
                overrun <= 1'b1;
            else if (dwnld_active && !active_q)
                overrun <= 1'b0;
        end
    end

    // NOTE: the word holding registers carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge clk_rom) begin
        if (accept) begin
            word_q <= dwnld_data;
            addr_q <= dwnld_addr[24:0] & ADDR_MASK;
            idx_q  <= dwnld_index;
        end
    end

    // Configuration bytes are snooped from the registered byte stream.
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            dipsw    <= '1;
            core_mod <= 7'b0000001;
        end else if (ioctl_wr) begin
            if (idx_q == DIP_INDEX) begin
                for (int n = 0; n < DIPBYTES; n++)
                    if (ioctl_addr == 25'(n))
                        dipsw[8*n +: 8] <= ioctl_data;
            end
            if (idx_q == MOD_INDEX && !ioctl_addr[0])
                core_mod <= ioctl_data[6:0];
        end
    end
endmodule

// File: tb/tb_jtframe_mr_dwnld.sv
// Scoreboard bench: a 16-bit/GAP=24 instance and a 32-bit/GAP=4 instance
// driven with directed and random words, checked against a byte-level model.
module tb_jtframe_mr_dwnld;
    logic        clk_rom = 1'b0;
    logic        rst = 1'b1;
    logic        wr_a = 1'b0, wr_b = 1'b0;
    logic [26:0] dwnld_addr = '0;
    logic [15:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic [7:0]  dwnld_index = '0;
    logic        dwnld_active = 1'b0;

    logic        a_wr, a_rom, a_busy, a_ovr, b_wr, b_rom, b_busy, b_ovr;
    logic [24:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic [31:0] a_dip, b_dip;
    logic [6:0]  a_mod, b_mod;

    always #5 clk_rom = ~clk_rom;

    jtframe_mr_dwnld #(.DIN_W(16), .GAP(24)) u_a (
        .clk_rom(clk_rom), .rst(rst), .dwnld_wr(wr_a), .dwnld_addr(dwnld_addr),
        .dwnld_data(data_a), .dwnld_index(dwnld_index), .dwnld_active(dwnld_active),
        .ioctl_wr(a_wr), .ioctl_addr(a_addr), .ioctl_data(a_data), .ioctl_rom_wr(a_rom),
        .dipsw(a_dip), .core_mod(a_mod), .busy(a_busy), .overrun(a_ovr));

    jtframe_mr_dwnld #(.DIN_W(32), .GAP(4)) u_b (
        .clk_rom(clk_rom), .rst(rst), .dwnld_wr(wr_b), .dwnld_addr(dwnld_addr),
        .dwnld_data(data_b), .dwnld_index(dwnld_index), .dwnld_active(dwnld_active),
        .ioctl_wr(b_wr), .ioctl_addr(b_addr), .ioctl_data(b_data), .ioctl_rom_wr(b_rom),
        .dipsw(b_dip), .core_mod(b_mod), .busy(b_busy), .overrun(b_ovr));

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        rom;
        int          cyc;
    } exp_t;

    exp_t        qa[$], qb[$];
    int          cyc = 0;
    int          checks = 0, failures = 0;
    int          bstart[2], bend[2];
    logic [7:0]  dip_m[2][4];
    logic [6:0]  mod_m[2];
    bit          ovr_m[2];
    logic [24:0] last_addr[2];
    logic [7:0]  last_data[2];

    always @(posedge clk_rom) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            bstart[s] = 0;
            bend[s]   = -1;
            for (int n = 0; n < 4; n++) dip_m[s][n] = 8'hff;
            mod_m[s]     = 7'd1;
            ovr_m[s]     = 1'b0;
            last_addr[s] = '0;
            last_data[s] = '0;
        end
        qa.delete();
        qb.delete();
    endtask

    function automatic logic [31:0] dip_exp(input int s);
        return {dip_m[s][3], dip_m[s][2], dip_m[s][1], dip_m[s][0]};
    endfunction

    // Model: a word accepted at cycle c emits byte j at c+1+j*(GAP+1); anything
    // arriving while the previous word still has a byte pending or emitting is dropped.
    task automatic issue(input int s, input logic [26:0] addr, input logic [31:0] data, input logic [7:0] idx);
        int          nb, sp, c;
        logic [24:0] base;
        exp_t        e;
        c    = cyc;
        nb   = s ? 4 : 2;
        sp   = s ? 5 : 25;
        base = addr[24:0] & (s ? ~25'd3 : ~25'd1);
        if (c > bend[s]) begin
            bstart[s] = c + 1;
            bend[s]   = c + 1 + (nb - 1) * sp;
            for (int j = 0; j < nb; j++) begin
                e.addr = base + 25'(j);
                e.data = data[8*j +: 8];
                e.rom  = (idx == 8'd0);
                e.cyc  = c + 1 + j * sp;
                if (s == 1) qb.push_back(e); else qa.push_back(e);
                if (idx == 8'd254 && e.addr < 25'd4) dip_m[s][e.addr[1:0]] = e.data;
                if (idx == 8'd1 && !e.addr[0]) mod_m[s] = e.data[6:0];
            end
        end else begin
            ovr_m[s] = 1'b1;
        end
        dwnld_addr  = addr;
        data_a      = data[15:0];
        data_b      = data;
        dwnld_index = idx;
        if (s == 1) wr_b = 1'b1; else wr_a = 1'b1;
        @(negedge clk_rom);
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic mon(input int s, input logic wr, input logic [24:0] addr, input logic [7:0] data,
                       input logic rom, input logic bsy);
        exp_t  e;
        bit    got;
        string p;
        p   = s ? "b" : "a";
        got = 1'b0;
        if (wr) begin
            if (s == 0 && qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
            if (s == 1 && qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_byte actual=%0h@%0h required=no byte cycle=%0d", p, data, addr, cyc);
            end else begin
                check({p, "_byte_addr"}, 64'(addr), 64'(e.addr));
                check({p, "_byte_data"}, 64'(data), 64'(e.data));
                check({p, "_byte_rom_wr"}, 64'(rom), 64'(e.rom));
                check({p, "_byte_cycle"}, 64'(cyc), 64'(e.cyc));
            end
            last_addr[s] = addr;
            last_data[s] = data;
        end else begin
            check({p, "_rom_wr_idle"}, 64'(rom), 64'd0);
            check({p, "_hold_addr"}, 64'(addr), 64'(last_addr[s]));
            check({p, "_hold_data"}, 64'(data), 64'(last_data[s]));
        end
        check({p, "_busy"}, 64'(bsy), 64'(cyc >= bstart[s] && cyc <= bend[s]));
    endtask

    always @(negedge clk_rom) begin
        if (!rst) begin
            mon(0, a_wr, a_addr, a_data, a_rom, a_busy);
            mon(1, b_wr, b_addr, b_data, b_rom, b_busy);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_rom);
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_a_dipsw"}, 64'(a_dip), 64'(dip_exp(0)));
        check({tag, "_b_dipsw"}, 64'(b_dip), 64'(dip_exp(1)));
        check({tag, "_a_core_mod"}, 64'(a_mod), 64'(mod_m[0]));
        check({tag, "_b_core_mod"}, 64'(b_mod), 64'(mod_m[1]));
    endtask

    task automatic active_rise();
        dwnld_active = 1'b0;
        @(negedge clk_rom);
        dwnld_active = 1'b1;
        @(negedge clk_rom);
        ovr_m[0] = 1'b0;
        ovr_m[1] = 1'b0;
        check("a_overrun_cleared", 64'(a_ovr), 64'd0);
        check("b_overrun_cleared", 64'(b_ovr), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_ioctl_wr"}, 64'(a_wr), 64'd0);
        check({tag, "_a_ioctl_addr"}, 64'(a_addr), 64'd0);
        check({tag, "_a_ioctl_data"}, 64'(a_data), 64'd0);
        check({tag, "_a_busy"}, 64'(a_busy), 64'd0);
        check({tag, "_a_overrun"}, 64'(a_ovr), 64'd0);
        check({tag, "_a_dipsw"}, 64'(a_dip), 64'hffffffff);
        check({tag, "_a_core_mod"}, 64'(a_mod), 64'd1);
        check({tag, "_b_busy"}, 64'(b_busy), 64'd0);
        check({tag, "_b_dipsw"}, 64'(b_dip), 64'hffffffff);
        check({tag, "_b_core_mod"}, 64'(b_mod), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          s, gap;
        logic [26:0] addr;
        logic [7:0]  idx;

        model_reset();
        wait_cyc(3);
        check_reset_values("reset");

        // Release reset and present a word on the very next edge.
        rst = 1'b0;
        issue(0, 27'h100, 32'h0000A55A, 8'd0);
        wait_cyc(30);
        check_cfg("rom_word");

        issue(1, 27'h8, 32'h04030201, 8'd0);
        wait_cyc(20);

        issue(0, 27'h0, 32'h00003412, 8'd254);
        wait_cyc(27);
        issue(0, 27'h2, 32'h00007856, 8'd254);
        wait_cyc(27);
        issue(0, 27'h4, 32'h0000FFEE, 8'd254);
        wait_cyc(27);
        check("dipsw_bytes", 64'(a_dip), 64'h78563412);
        check_cfg("dip_words");

        issue(0, 27'h0, 32'h00007F05, 8'd1);
        wait_cyc(27);
        check("core_mod_even_only", 64'(a_mod), 64'h05);
        check_cfg("mod_word");

        active_rise();
        issue(0, 27'h200, 32'h00001234, 8'd0);
        wait_cyc(2);
        issue(0, 27'h300, 32'h0000DEAD, 8'd0);
        wait_cyc(30);
        check("overrun_set", 64'(a_ovr), 64'd1);
        check("overrun_b_untouched", 64'(b_ovr), 64'd0);
        active_rise();

        // Reset while the 16-bit instance sits in its inter-byte gap.
        issue(0, 27'h20, 32'h00002211, 8'd1);
        wait_cyc(5);
        #1 rst = 1'b1;
        model_reset();
        wait_cyc(2);
        check_reset_values("mid_word_reset");
        rst = 1'b0;
        wait_cyc(40);

        active_rise();
        for (int i = 0; i < 60; i++) begin
            s    = int'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0:       idx = 8'd0;
                1:       idx = 8'd1;
                2:       idx = 8'd254;
                default: idx = 8'h37;
            endcase
            issue(s, addr, $urandom, idx);
            gap = int'($urandom_range(0, 30));
            wait_cyc(gap);
        end
        wait_cyc(40);
        check_cfg("random");
        check("random_a_overrun", 64'(a_ovr), 64'(ovr_m[0]));
        check("random_b_overrun", 64'(b_ovr), 64'(ovr_m[1]));
        active_rise();

        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
